rf_wr_arbiter: RTL and testbench

Write-port arbiter for the 32x32 register file in the pipelined CPU. Shares the register file's single write port between the pipeline writeback stage (MEM/WB) and one auxiliary requester (multi-cycle unit or debug loader). Auxiliary writes are buffered in a small FIFO, cancelled if overtaken by a younger writeback to the same register, and forced through by a starvation stall. Exposes pending-write hit flags so decode can stall on reads of buffered registers.

---
 rtl/rf_wr_arbiter.sv | 158 +++++++++++++++
 tb/tb_rf_wr_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wr_arbiter.sv
// rf_wr_arbiter: shares the register-file write port between writeback and an
// auxiliary FIFO, with cancellation, starvation stall and pending-read hit flags.
//
// Ports:
//   clk, rst                      clock, async active-low reset
//   wb_we/wb_rd/wb_wd             pipeline writeback (always granted)
//   aux_valid/aux_ready/aux_rd/aux_wd  auxiliary write request into FIFO
//   rd_a1/rd_a2, pend_hit1/2      decode reads that hit a buffered entry
//   rf_we/rf_a3/rf_wd             register-file write port
//   stall_req                     freeze request so the FIFO head can drain
//   cancel_cnt                    saturating count of cancelled entries
module rf_wr_arbiter #(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_wd,
  input  logic        aux_valid,
  output logic        aux_ready,
  input  logic [4:0]  aux_rd,
  input  logic [31:0] aux_wd,
  input  logic [4:0]  rd_a1,
  input  logic [4:0]  rd_a2,
  output logic        pend_hit1,
  output logic        pend_hit2,
  output logic        rf_we,
  output logic [4:0]  rf_a3,
  output logic [31:0] rf_wd,
  output logic        stall_req,
  output logic [7:0]  cancel_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]    wp_q, rp_q;
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [4:0]       rd_q [DEPTH];
  logic [31:0]      wd_q [DEPTH];
  logic [7:0]       wait_q, wait_d;
  logic [7:0]       ccnt_q, ccnt_d;
  logic             stall_q, stall_d;

  logic             empty, full, accept, push, pop;
  logic [AW-1:0]    hidx, widx;
  logic [DEPTH-1:0] can;
  logic [8:0]       nsum;

  assign hidx  = rp_q[AW-1:0];
  assign widx  = wp_q[AW-1:0];
  assign empty = (wp_q == rp_q);
  assign full  = (widx == hidx) && (wp_q[AW] != rp_q[AW]);

  assign aux_ready = !full;
  assign accept    = aux_valid && !full;
  // x0 requests are accepted but occupy no slot
  assign push      = accept && (aux_rd != 5'd0);
  assign pop       = !wb_we && !empty;

  assign stall_req  = stall_q;
  assign cancel_cnt = ccnt_q;

  // Grant; outputs held at zero while reset is asserted
  always_comb begin
    rf_we = 1'b0;
    rf_a3 = 5'd0;
    rf_wd = 32'd0;
    if (!rst) begin
      rf_we = 1'b0;
    end else if (wb_we) begin
      rf_we = 1'b1;
      rf_a3 = wb_rd;
      rf_wd = wb_wd;
    end else if (!empty) begin
      rf_we = vld_q[hidx];
      rf_a3 = rd_q[hidx];
      rf_wd = wd_q[hidx];
    end
  end

  always_comb begin
    pend_hit1 = 1'b0;
    pend_hit2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && rd_q[i] == rd_a1 && rd_a1 != 5'd0)
        pend_hit1 = 1'b1;
      if (vld_q[i] && rd_q[i] == rd_a2 && rd_a2 != 5'd0)
        pend_hit2 = 1'b1;
    end
  end

  // A younger writeback kills every older buffered write to the same reg
  always_comb begin
    nsum = {1'b0, ccnt_q};
    for (int i = 0; i < DEPTH; i++) begin
      can[i] = wb_we && (wb_rd != 5'd0) &&
               vld_q[i] && (rd_q[i] == wb_rd);
      nsum = nsum + 9'(can[i]);
    end
    ccnt_d = (nsum > 9'd255) ? 8'd255 : nsum[7:0];
  end

  // Pop and cancel are exclusive (pop needs !wb_we); the push slot is free,
  // so a same-cycle push is stored valid even if wb_rd matches it.
  always_comb begin
    vld_d = vld_q & ~can;
    if (pop)
      vld_d[hidx] = 1'b0;
    if (push)
      vld_d[widx] = 1'b1;
  end

  always_comb begin
    if (empty || pop)
      wait_d = 8'd0;
    else if (wait_q != 8'hFF)
      wait_d = wait_q + 8'd1;
    else
      wait_d = wait_q;
    if (wait_d >= 8'(MAX_WAIT))
      stall_d = 1'b1;
    else if (pop)
      stall_d = 1'b0;
    else
      stall_d = stall_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      vld_q   <= '0;
      wait_q  <= 8'd0;
      ccnt_q  <= 8'd0;
      stall_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i] <= 5'd0;
        wd_q[i] <= 32'd0;
      end
    end else begin
      vld_q   <= vld_d;
      wait_q  <= wait_d;
      ccnt_q  <= ccnt_d;
      stall_q <= stall_d;
      if (push) begin
        rd_q[widx] <= aux_rd;
        wd_q[widx] <= aux_wd;
        wp_q       <= wp_q + PW'(1);
      end
      if (pop)
        rp_q <= rp_q + PW'(1);
    end
  end

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// tb_rf_wr_arbiter: directed self-checking bench for rf_wr_arbiter
// (DEPTH=2, MAX_WAIT=4), hand-computed expectations.
module tb_rf_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_wd;
  logic        aux_valid;
  logic        aux_ready;
  logic [4:0]  aux_rd;
  logic [31:0] aux_wd;
  logic [4:0]  rd_a1, rd_a2;
  logic        pend_hit1, pend_hit2;
  logic        rf_we;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd;
  logic        stall_req;
  logic [7:0]  cancel_cnt;

  int tests = 0;
  int fails = 0;

  rf_wr_arbiter #(.DEPTH(2), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_wd(wb_wd),
    .aux_valid(aux_valid), .aux_ready(aux_ready),
    .aux_rd(aux_rd), .aux_wd(aux_wd),
    .rd_a1(rd_a1), .rd_a2(rd_a2),
    .pend_hit1(pend_hit1), .pend_hit2(pend_hit2),
    .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd(rf_wd),
    .stall_req(stall_req), .cancel_cnt(cancel_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    wb_we = 1'b1; wb_rd = 5'd3; wb_wd = 32'hDEAD0003;
    aux_valid = 1'b0; aux_rd = 5'd0; aux_wd = 32'd0;
    rd_a1 = 5'd0; rd_a2 = 5'd0;
    #2;
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_rf_a3", 32'(rf_a3), 32'd0);
    chk("rst_rf_wd", rf_wd, 32'd0);
    chk("rst_ready", 32'(aux_ready), 32'd1);
    chk("rst_stall", 32'(stall_req), 32'd0);
    chk("rst_ccnt", 32'(cancel_cnt), 32'd0);
    chk("rst_hit1", 32'(pend_hit1), 32'd0);
    tick();
    rst = 1'b1;
    wb_we = 1'b0;

    // single aux write
    tick();
    aux_valid = 1'b1; aux_rd = 5'd5; aux_wd = 32'hA5A5A5A5;
    rd_a1 = 5'd5;
    #1;
    chk("t1_ready", 32'(aux_ready), 32'd1);
    chk("t1_nowr", 32'(rf_we), 32'd0);
    chk("t1_nohit", 32'(pend_hit1), 32'd0);
    tick();
    aux_valid = 1'b0;
    #1;
    chk("t1_we", 32'(rf_we), 32'd1);
    chk("t1_a3", 32'(rf_a3), 32'd5);
    chk("t1_wd", rf_wd, 32'hA5A5A5A5);
    chk("t1_hit", 32'(pend_hit1), 32'd1);
    tick();
    chk("t1_empty_we", 32'(rf_we), 32'd0);
    chk("t1_empty_hit", 32'(pend_hit1), 32'd0);

    // writeback priority, fill FIFO
    wb_we = 1'b1; wb_rd = 5'd10; wb_wd = 32'h11111111;
    aux_valid = 1'b1; aux_rd = 5'd12; aux_wd = 32'h12121212;
    tick();
    aux_rd = 5'd13; aux_wd = 32'h13131313;
    #1;
    chk("t2_wb_a3_a", 32'(rf_a3), 32'd10);
    tick();
    aux_valid = 1'b0;
    rd_a1 = 5'd12; rd_a2 = 5'd13;
    #1;
    chk("t2_full", 32'(aux_ready), 32'd0);
    chk("t2_we", 32'(rf_we), 32'd1);
    chk("t2_a3", 32'(rf_a3), 32'd10);
    chk("t2_wd", rf_wd, 32'h11111111);
    chk("t2_hit1", 32'(pend_hit1), 32'd1);
    chk("t2_hit2", 32'(pend_hit2), 32'd1);
    rd_a1 = 5'd14;
    #1;
    chk("t2_miss", 32'(pend_hit1), 32'd0);
    wb_we = 1'b0;
    #1;
    chk("t2_drain0_a3", 32'(rf_a3), 32'd12);
    chk("t2_drain0_wd", rf_wd, 32'h12121212);
    tick();
    chk("t2_ready_after", 32'(aux_ready), 32'd1);
    chk("t2_drain1_a3", 32'(rf_a3), 32'd13);
    chk("t2_drain1_we", 32'(rf_we), 32'd1);
    tick();
    chk("t2_empty", 32'(rf_we), 32'd0);
    chk("t2_nostall", 32'(stall_req), 32'd0);
    rd_a2 = 5'd0;

    // starvation
    wb_we = 1'b1; wb_rd = 5'd1; wb_wd = 32'h00000001;
    aux_valid = 1'b1; aux_rd = 5'd20; aux_wd = 32'h20202020;
    tick();
    aux_valid = 1'b0;
    #1;
    chk("t3_c1_stall", 32'(stall_req), 32'd0);
    tick();
    tick();
    tick();
    chk("t3_c4_stall", 32'(stall_req), 32'd0);
    tick();
    chk("t3_c5_stall", 32'(stall_req), 32'd1);
    chk("t3_c5_wbwins", 32'(rf_a3), 32'd1);
    wb_we = 1'b0;
    #1;
    chk("t3_drain_we", 32'(rf_we), 32'd1);
    chk("t3_drain_a3", 32'(rf_a3), 32'd20);
    chk("t3_drain_wd", rf_wd, 32'h20202020);
    tick();
    chk("t3_stall_clr", 32'(stall_req), 32'd0);
    chk("t3_empty", 32'(rf_we), 32'd0);

    // cancellation
    aux_valid = 1'b1; aux_rd = 5'd7; aux_wd = 32'h77777777;
    tick();
    aux_valid = 1'b0;
    wb_we = 1'b1; wb_rd = 5'd7; wb_wd = 32'h70707070;
    rd_a1 = 5'd7;
    #1;
    chk("t4_hit_pre", 32'(pend_hit1), 32'd1);
    chk("t4_ccnt_pre", 32'(cancel_cnt), 32'd0);
    tick();
    wb_we = 1'b0;
    #1;
    chk("t4_ccnt", 32'(cancel_cnt), 32'd1);
    chk("t4_hit_clr", 32'(pend_hit1), 32'd0);
    chk("t4_pop_nowr", 32'(rf_we), 32'd0);
    tick();
    chk("t4_empty_we", 32'(rf_we), 32'd0);

    // x0 accepted, never written
    aux_valid = 1'b1; aux_rd = 5'd0; aux_wd = 32'hFFFFFFFF;
    rd_a1 = 5'd0;
    #1;
    chk("t5_x0_ready", 32'(aux_ready), 32'd1);
    tick();
    aux_valid = 1'b0;
    #1;
    chk("t5_x0_nowr", 32'(rf_we), 32'd0);
    chk("t5_x0_nohit", 32'(pend_hit1), 32'd0);

    // same-cycle push and matching writeback: aux is younger
    wb_we = 1'b1; wb_rd = 5'd9; wb_wd = 32'h99999999;
    aux_valid = 1'b1; aux_rd = 5'd9; aux_wd = 32'h9A9A9A9A;
    tick();
    aux_valid = 1'b0; wb_we = 1'b0;
    rd_a1 = 5'd9;
    #1;
    chk("t5_same_hit", 32'(pend_hit1), 32'd1);
    chk("t5_same_ccnt", 32'(cancel_cnt), 32'd1);
    chk("t5_same_we", 32'(rf_we), 32'd1);
    chk("t5_same_a3", 32'(rf_a3), 32'd9);
    chk("t5_same_wd", rf_wd, 32'h9A9A9A9A);
    tick();
    chk("t5_same_done", 32'(rf_we), 32'd0);

    // async reset with full FIFO and stall active
    wb_we = 1'b1; wb_rd = 5'd2; wb_wd = 32'h22222222;
    aux_valid = 1'b1; aux_rd = 5'd3; aux_wd = 32'h33333333;
    tick();
    aux_rd = 5'd4; aux_wd = 32'h44444444;
    tick();
    aux_valid = 1'b0;
    rd_a1 = 5'd3; rd_a2 = 5'd4;
    tick();
    tick();
    tick();
    chk("t6_stall", 32'(stall_req), 32'd1);
    chk("t6_full", 32'(aux_ready), 32'd0);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_rf_we", 32'(rf_we), 32'd0);
    chk("t6_rf_a3", 32'(rf_a3), 32'd0);
    chk("t6_rf_wd", rf_wd, 32'd0);
    chk("t6_stall_clr", 32'(stall_req), 32'd0);
    chk("t6_ready", 32'(aux_ready), 32'd1);
    chk("t6_hit1", 32'(pend_hit1), 32'd0);
    chk("t6_hit2", 32'(pend_hit2), 32'd0);
    chk("t6_ccnt", 32'(cancel_cnt), 32'd0);
    wb_we = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("t6_post_we", 32'(rf_we), 32'd0);
    tick();
    chk("t6_post_we2", 32'(rf_we), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
